regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file with integrated write-back scoreboard. It succeeds the single-read/single-write integer file.
- Serves both the integer file (x0 hardwired to zero) and the F-extension file (f0 writable, 3 read ports for fused multiply-add).
- Sits between decode/issue, which reads operands and marks destinations busy, and write-back, which commits results and clears busy.
- Provides same-cycle write-to-read bypass and reset of all architectural state.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, 2..64. Localparam AW = $clog2(NREGS).
- NUM_RD, 2, number of read ports, 1..4.
- NUM_WR, 1, number of write ports, 1..2.
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy.
- BYPASS, 1, 1 = a read of an address being written this cycle returns the write data.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- rd_addr_i  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data_o  out  NUM_RD*XLEN  read data, combinational from address.
- rd_busy_o  out  NUM_RD  1 = operand of port k has a pending write (issue must stall).
- wr_en_i  in  NUM_WR  write enable per port (the data_valid equivalent).
- wr_addr_i  in  NUM_WR*AW  write addresses.
- wr_data_i  in  NUM_WR*XLEN  write data.
- iss_valid_i  in  1  an instruction with a destination issues this cycle.
- iss_rd_i  in  AW  destination of the issuing instruction.
- flush_i  in  1  synchronous pipeline flush; clears all busy bits.
- busy_o  out  NREGS  full scoreboard vector (debug / hazard unit).

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all busy bits = 0. Outputs follow combinationally: rd_data_o = 0, rd_busy_o = 0, busy_o = 0. Reset asserted mid-operation discards pending writes and the scoreboard.
- Write: at posedge clk, for each port j with wr_en_i[j]=1, reg[wr_addr_j] <= wr_data_j. Latency is 1 cycle to storage.
- Write to the same address on two ports in one cycle: the higher port index wins.
- ZERO_REG=1: writes to address 0 are dropped. Reads of address 0 return 0 regardless of bypass.
- Read is combinational, 0-cycle latency.
- BYPASS=1: if any enabled write port matches the read address (and the address is nonzero or ZERO_REG=0), return that port's data; the highest matching port wins. Otherwise return stored data.
- BYPASS=0: reads return stored data, so the new value is visible the cycle after the write.
- Scoreboard update at posedge, in priority order:
  1. flush_i=1: busy <= 0; an iss_valid_i in the same cycle is ignored.
  2. Otherwise, every enabled write port clears busy[wr_addr_j].
  3. Then iss_valid_i sets busy[iss_rd_i]. A set and a clear of the same register in the same cycle results in set, because the issuing instruction is younger.
  - ZERO_REG=1: busy[0] is never set.
  - Register writes are never blocked by flush_i.
- rd_busy_o[k] = busy[rd_addr_k], except:
  - forced 0 when BYPASS=1 and a write port matches the address this cycle (data is being forwarded);
  - forced 0 for address 0 when ZERO_REG=1.
- Re-issue to an already busy register keeps the bit at 1. There is no counting; the in-order pipeline guarantees a single outstanding writer per register.
- Out-of-range addresses cannot occur because NREGS = 2^AW.

Decomposition:
- Shared package rf_pkg:
  - localparam helpers: function for AW, XLEN_DEF = 32.
  - typedef for reg index.
  - constants ZERO_IDX = 0 and IREG_NUM / FREG_NUM = 32.
- One natural sub-module, rf_scoreboard. It holds the busy vector, issue set / write-back clear / flush, and the per-read-port busy lookup with bypass masking.
- Storage, write arbitration and the read/bypass muxes stay in regfile_mp.

Test Plan:
1. Reset: rst=0 during random writes, then release → every rd_data_o = 0 and busy_o = 0 immediately after rst falls. A write of 0xDEADBEEF to x5 after release reads back 0xDEADBEEF the next cycle.
2. x0: ZERO_REG=1, write 0x12345678 to addr 0 with iss_rd_i=0 → rd_data_o = 0 and busy_o[0] = 0. Repeat with ZERO_REG=0 → reads 0x12345678.
3. Bypass: with x7 = 0x1, in the same cycle write 0xCAFEF00D to x7 and read x7 on both ports → both return 0xCAFEF00D in that cycle. With BYPASS=0 → returns 0x1, then 0xCAFEF00D the next cycle.
4. Dual-write collision: NUM_WR=2, both ports write x3 (0xAAAA / 0xBBBB) → stored and bypassed value = 0xBBBB.
5. Scoreboard: issue x9 → busy_o[9]=1 and rd_busy_o=1 the next cycle. Write-back x9 together with iss_rd_i=9 in the same cycle → busy stays 1. Write-back alone → 0. With BYPASS=1, rd_busy_o for x9 is 0 during the write-back cycle.
6. Flush: set busy on x1, x2, x31, then flush_i=1 with iss_valid_i=1 (x4) → busy_o = 0 the next cycle and the x4 issue is dropped; a concurrent write to x2 still updates storage.

Source files
------------

// File: rtl/rf_pkg.sv
// ============================================================================
// Module  : rf_pkg
// Brief   : Shared types, constants and helpers for the multi-port reg file.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int XLEN_DEF = 32;
  localparam int IREG_NUM = 32;
  localparam int FREG_NUM = 32;
  localparam int ZERO_IDX = 0;

  typedef logic [$clog2(IREG_NUM)-1:0] reg_idx_t;

  // Width of a register index; a single-entry file still needs one bit.
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module  : rf_scoreboard
// Brief   : Busy-bit scoreboard: issue set, write-back clear, flush, lookup.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS    = IREG_NUM,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  input  logic                 iss_valid_i,
  input  logic [AW-1:0]        iss_rd_i,
  input  logic                 flush_i,
  output logic [NUM_RD-1:0]    rd_busy_o,
  output logic [NREGS-1:0]     busy_o
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Issue is applied after write-back so the younger instruction's set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush_i) begin
      w_busy_nxt = '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en_i[j]) w_busy_nxt[wr_addr_i[j*AW +: AW]] = 1'b0;
      end
      if (iss_valid_i) w_busy_nxt[iss_rd_i] = 1'b1;
    end
    if (ZERO_REG != 0) w_busy_nxt[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

  assign busy_o = r_busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_fwd;
    logic          w_zero;

    assign w_addr = rd_addr_i[k*AW +: AW];
    assign w_zero = (ZERO_REG != 0) && (w_addr == '0);

    always_comb begin
      w_fwd = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == w_addr)) w_fwd = 1'b1;
        end
      end
    end

    assign rd_busy_o[k] = r_busy[w_addr] && !w_fwd && !w_zero;
  end : g_rd

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module  : regfile_mp
// Brief   : Parametrised multi-port register file with write-back scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = IREG_NUM,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic [NUM_WR-1:0]      wr_en_i,
  input  logic [NUM_WR*AW-1:0]   wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0] wr_data_i,
  input  logic                   iss_valid_i,
  input  logic [AW-1:0]          iss_rd_i,
  input  logic                   flush_i,
  output logic [NREGS-1:0]       busy_o
);

  logic [XLEN-1:0] r_regs [NREGS];

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regs <= '{default: '0};
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en_i[j] && !((ZERO_REG != 0) && (wr_addr_i[j*AW +: AW] == '0)))
          r_regs[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;

    assign w_addr = rd_addr_i[k*AW +: AW];

    // Reset masks forwarding too, so reads are zero while rst is low.
    always_comb begin
      w_data = r_regs[w_addr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == w_addr))
            w_data = wr_data_i[j*XLEN +: XLEN];
        end
      end
      if ((ZERO_REG != 0) && (w_addr == '0)) w_data = '0;
      if (!rst) w_data = '0;
    end

    assign rd_data_o[k*XLEN +: XLEN] = w_data;
  end : g_rd

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_i   (rd_addr_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .flush_i     (flush_i),
    .rd_busy_o   (rd_busy_o),
    .busy_o      (busy_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module  : tb_regfile_mp
// Brief   : Scoreboard bench for regfile_mp in two configurations.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Config A: 3 read, 2 write, x0 hardwired, bypass on
  logic [14:0] a_rd_addr;
  logic [95:0] a_rd_data;
  logic [2:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_iss_valid;
  logic [4:0]  a_iss_rd;
  logic        a_flush;
  logic [31:0] a_busy;

  // Config B: 2 read, 1 write, f0 writable, no bypass
  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [0:0]  b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_iss_valid;
  logic [4:0]  b_iss_rd;
  logic        b_flush;
  logic [31:0] b_busy;

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(3), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data), .rd_busy_o(a_rd_busy),
    .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
    .iss_valid_i(a_iss_valid), .iss_rd_i(a_iss_rd), .flush_i(a_flush), .busy_o(a_busy));

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data), .rd_busy_o(b_rd_busy),
    .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
    .iss_valid_i(b_iss_valid), .iss_rd_i(b_iss_rd), .flush_i(b_flush), .busy_o(b_busy));

  // Observed signal selectors
  localparam int A_DATA = 0, A_RBUSY = 1, A_BUSY = 2, B_DATA = 3, B_BUSY = 4, A_BVEC = 5;
  localparam int C_TIMEOUT = 100000;

  typedef struct {
    int          sig;
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic r_done = 1'b0;

  task automatic push(input int sig, input int idx, input logic [31:0] exp, input string name);
    exp_t e;
    e.sig = sig; e.idx = idx; e.exp = exp; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
    a_iss_valid = 1'b0; a_iss_rd = '0; a_flush = 1'b0;
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_iss_valid = 1'b0; b_iss_rd = '0; b_flush = 1'b0;
  endtask

  task automatic a_rd(input int port, input logic [4:0] addr);
    a_rd_addr[port*5 +: 5] = addr;
  endtask

  task automatic a_wr(input int port, input logic [4:0] addr, input logic [31:0] d);
    a_wr_en[port] = 1'b1;
    a_wr_addr[port*5 +: 5] = addr;
    a_wr_data[port*32 +: 32] = d;
  endtask

  task automatic b_rd(input int port, input logic [4:0] addr);
    b_rd_addr[port*5 +: 5] = addr;
  endtask

  task automatic b_wr(input logic [4:0] addr, input logic [31:0] d);
    b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = d;
  endtask

  // Monitor: outputs are combinational, so they are presented every cycle;
  // compare everything queued for this cycle at the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sig)
        A_DATA:  act = a_rd_data[e.idx*32 +: 32];
        A_RBUSY: act = {31'b0, a_rd_busy[e.idx]};
        A_BUSY:  act = {31'b0, a_busy[e.idx]};
        B_DATA:  act = b_rd_data[e.idx*32 +: 32];
        B_BUSY:  act = {31'b0, b_busy[e.idx]};
        default: act = a_busy;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", e.name, act, e.exp, $time);
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded time.
  initial begin
    #(C_TIMEOUT);
    if (!r_done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete within %0d time units", C_TIMEOUT);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    // Reset with garbage writes and an issue in flight
    tick();
    rst = 1'b0;
    a_wr(0, 5'd5, $urandom); a_wr(1, 5'd6, $urandom);
    a_iss_valid = 1'b1; a_iss_rd = 5'd5;
    b_wr(5'd5, $urandom);
    a_rd(0, 5'd5); a_rd(1, 5'd6); a_rd(2, 5'd0); b_rd(0, 5'd5);
    #1;
    checks++;
    if ((a_busy !== 32'h0) || (b_busy !== 32'h0) || (a_rd_data !== 96'h0) ||
        (b_rd_data !== 64'h0) || (a_rd_busy !== 3'b0) || (b_rd_busy !== 2'b0)) begin
      errors++;
      $display("FAIL reset_state: a_busy=0x%08h b_busy=0x%08h a_data=0x%024h b_data=0x%016h @%0t",
               a_busy, b_busy, a_rd_data, b_rd_data, $time);
    end
    push(A_DATA, 0, 32'h0, "rst_a_p0"); push(A_DATA, 1, 32'h0, "rst_a_p1");
    push(A_DATA, 2, 32'h0, "rst_a_p2"); push(B_DATA, 0, 32'h0, "rst_b_p0");
    push(A_BVEC, 0, 32'h0, "rst_busy_vec"); push(A_RBUSY, 0, 32'h0, "rst_rbusy");
    tick(); rst = 1'b1;

    // Write and issue, then assert reset mid-operation
    tick();
    a_wr(0, 5'd10, 32'h55AA55AA); a_iss_valid = 1'b1; a_iss_rd = 5'd11; a_rd(0, 5'd10);
    push(A_DATA, 0, 32'h55AA55AA, "pre_rst_bypass");
    tick();
    a_rd(0, 5'd10);
    push(A_DATA, 0, 32'h55AA55AA, "pre_rst_stored"); push(A_BUSY, 11, 32'h1, "pre_rst_busy11");
    tick();
    rst = 1'b0; a_wr(0, 5'd10, 32'h00000077); a_rd(0, 5'd10);
    push(A_DATA, 0, 32'h0, "midrst_read"); push(A_BVEC, 0, 32'h0, "midrst_busy_vec");
    tick(); rst = 1'b1;
    tick();
    a_rd(0, 5'd10); a_rd(1, 5'd11);
    push(A_DATA, 0, 32'h0, "post_rst_x10"); push(A_RBUSY, 1, 32'h0, "post_rst_rbusy11");

    // x5 write-then-read
    tick();
    a_wr(0, 5'd5, 32'hDEADBEEF); b_wr(5'd5, 32'hDEADBEEF);
    tick();
    a_rd(0, 5'd5); b_rd(0, 5'd5);
    push(A_DATA, 0, 32'hDEADBEEF, "x5_a"); push(B_DATA, 0, 32'hDEADBEEF, "x5_b");

    // Register zero, hardwired vs writable
    tick();
    a_wr(0, 5'd0, 32'h12345678); a_iss_valid = 1'b1; a_iss_rd = 5'd0; a_rd(0, 5'd0);
    b_wr(5'd0, 32'h12345678); b_iss_valid = 1'b1; b_iss_rd = 5'd0; b_rd(0, 5'd0);
    push(A_DATA, 0, 32'h0, "x0_a_bypass"); push(B_DATA, 0, 32'h0, "f0_b_nobypass");
    tick();
    a_rd(0, 5'd0); b_rd(0, 5'd0);
    push(A_DATA, 0, 32'h0, "x0_a_stored"); push(A_BUSY, 0, 32'h0, "x0_a_busy");
    push(A_RBUSY, 0, 32'h0, "x0_a_rbusy"); push(B_DATA, 0, 32'h12345678, "f0_b_stored");
    push(B_BUSY, 0, 32'h1, "f0_b_busy");

    // Bypass vs no bypass on x7
    tick();
    a_wr(0, 5'd7, 32'h1); b_wr(5'd7, 32'h1);
    tick();
    a_wr(0, 5'd7, 32'hCAFEF00D); a_rd(0, 5'd7); a_rd(1, 5'd7);
    b_wr(5'd7, 32'hCAFEF00D); b_rd(0, 5'd7); b_rd(1, 5'd7);
    push(A_DATA, 0, 32'hCAFEF00D, "byp_a_p0"); push(A_DATA, 1, 32'hCAFEF00D, "byp_a_p1");
    push(B_DATA, 0, 32'h1, "nobyp_b_p0"); push(B_DATA, 1, 32'h1, "nobyp_b_p1");
    tick();
    a_rd(2, 5'd7); b_rd(0, 5'd7);
    push(A_DATA, 2, 32'hCAFEF00D, "x7_a_next"); push(B_DATA, 0, 32'hCAFEF00D, "x7_b_next");

    // Dual-write collision on x3
    tick();
    a_wr(0, 5'd3, 32'h0000AAAA); a_wr(1, 5'd3, 32'h0000BBBB); a_rd(0, 5'd3);
    push(A_DATA, 0, 32'h0000BBBB, "collide_bypass");
    tick();
    a_rd(1, 5'd3);
    push(A_DATA, 1, 32'h0000BBBB, "collide_stored");

    // Scoreboard on x9
    tick();
    a_iss_valid = 1'b1; a_iss_rd = 5'd9; a_rd(0, 5'd9);
    push(A_RBUSY, 0, 32'h0, "x9_before_set");
    tick();
    a_rd(0, 5'd9);
    push(A_BUSY, 9, 32'h1, "x9_busy"); push(A_RBUSY, 0, 32'h1, "x9_rbusy");
    tick();
    a_wr(1, 5'd9, 32'h99); a_iss_valid = 1'b1; a_iss_rd = 5'd9; a_rd(0, 5'd9);
    push(A_RBUSY, 0, 32'h0, "x9_wb_masked"); push(A_DATA, 0, 32'h99, "x9_wb_data");
    tick();
    a_rd(0, 5'd9);
    push(A_BUSY, 9, 32'h1, "x9_set_wins"); push(A_RBUSY, 0, 32'h1, "x9_rbusy_again");
    tick();
    a_wr(0, 5'd9, 32'h9A); a_rd(0, 5'd9);
    push(A_RBUSY, 0, 32'h0, "x9_wb2_masked");
    tick();
    a_rd(0, 5'd9);
    push(A_BUSY, 9, 32'h0, "x9_cleared"); push(A_RBUSY, 0, 32'h0, "x9_rbusy_clr");
    push(A_DATA, 0, 32'h9A, "x9_data");

    // Flush with concurrent issue and write
    tick(); a_iss_valid = 1'b1; a_iss_rd = 5'd1;
    tick(); a_iss_valid = 1'b1; a_iss_rd = 5'd2;
    tick(); a_iss_valid = 1'b1; a_iss_rd = 5'd31;
    tick();
    a_flush = 1'b1; a_iss_valid = 1'b1; a_iss_rd = 5'd4;
    a_wr(0, 5'd2, 32'h2222); a_rd(0, 5'd2);
    push(A_BVEC, 0, 32'h80000006, "pre_flush_vec"); push(A_DATA, 0, 32'h2222, "flush_bypass");
    push(A_RBUSY, 0, 32'h0, "flush_rbusy_x2");
    tick();
    a_rd(0, 5'd2); a_rd(1, 5'd4);
    push(A_BVEC, 0, 32'h0, "post_flush_vec"); push(A_DATA, 0, 32'h2222, "flush_write_kept");
    push(A_RBUSY, 1, 32'h0, "flush_drop_x4");

    @(negedge clk);
    #1;
    r_done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
